// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 sliding-window generator.
// Holds default geometry, counter-width helper and window tap indices.
// Tap order is row-major and matches the conv unit a00..a22 operand order.
package conv_pkg;

   localparam int DEF_WIDTH = 9;
   localparam int DEF_IMG_W = 28;
   localparam int DEF_IMG_H = 28;

   localparam int NUM_TAPS = 9;
   localparam int W00 = 0;
   localparam int W01 = 1;
   localparam int W02 = 2;
   localparam int W10 = 3;
   localparam int W11 = 4;
   localparam int W12 = 5;
   localparam int W20 = 6;
   localparam int W21 = 7;
   localparam int W22 = 8;

   // Bits needed to count 0..value-1; never less than one bit.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage, addressed by column.
// Read is combinational (old contents), write lands on the clock edge.
// No flow control: caller asserts i_we only on an accepted pixel.
module line_buffer #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 28,
   parameter int AW    = 5
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_dat,
   output logic [WIDTH-1:0] o_dat
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Contents are don't-care after reset: stale entries never reach a valid window.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_dat;
   end

   assign o_dat = r_mem[i_addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator over a raster pixel stream (stride 1, no padding).
// Latency: window valid one cycle after accepting its bottom-right pixel.
// Backpressure: pix_ready = !win_valid || win_ready; stalled window holds, no skid buffer.
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             pix_sof,
   output logic             pix_ready,
   output logic [WIDTH-1:0] w00,
   output logic [WIDTH-1:0] w01,
   output logic [WIDTH-1:0] w02,
   output logic [WIDTH-1:0] w10,
   output logic [WIDTH-1:0] w11,
   output logic [WIDTH-1:0] w12,
   output logic [WIDTH-1:0] w20,
   output logic [WIDTH-1:0] w21,
   output logic [WIDTH-1:0] w22,
   output logic             win_valid,
   input  logic             win_ready,
   output logic             frame_done
);

   localparam int CW = clog2(IMG_W);
   localparam int RW = clog2(IMG_H);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [WIDTH-1:0] r_win [NUM_TAPS];
   logic             r_vld;
   logic             r_done;

   logic             w_acc;
   logic [CW-1:0]    w_col;
   logic [RW-1:0]    w_row;
   logic             w_qual;
   logic             w_last;
   logic [WIDTH-1:0] w_lb0;
   logic [WIDTH-1:0] w_lb1;

   assign pix_ready = !r_vld || win_ready;
   assign w_acc     = pix_valid && pix_ready;

   // A start-of-frame pixel is placed at (0,0) whatever the counters say.
   assign w_col  = pix_sof ? '0 : r_col;
   assign w_row  = pix_sof ? '0 : r_row;
   assign w_qual = (w_row >= RW'(2)) && (w_col >= CW'(2));
   assign w_last = (w_row == LAST_ROW) && (w_col == LAST_COL);

   // lb0 holds the previous row, lb1 the row before; lb0 cascades into lb1.
   line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
      .i_clk (clk),
      .i_we  (w_acc),
      .i_addr(w_col),
      .i_dat (pix_in),
      .o_dat (w_lb0)
   );

   line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
      .i_clk (clk),
      .i_we  (w_acc),
      .i_addr(w_col),
      .i_dat (w_lb0),
      .o_dat (w_lb1)
   );

   // Raster position counters; they double as the FILL/STREAM sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_acc) begin
         if (w_col == LAST_COL) begin
            r_col <= '0;
            r_row <= (w_row == LAST_ROW) ? '0 : w_row + 1'b1;
         end else begin
            r_col <= w_col + 1'b1;
            r_row <= w_row;
         end
      end
   end

   // Valid follows a qualifying accept; frame_done lasts only the window's first cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= 1'b0;
         r_done <= 1'b0;
      end else if (w_acc) begin
         r_vld  <= w_qual;
         r_done <= w_qual && w_last;
      end else begin
         if (win_ready) r_vld <= 1'b0;
         r_done <= 1'b0;
      end
   end

   // Window shifts left one column per accept; new column comes from the line buffers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_TAPS; i++) r_win[i] <= '0;
      end else if (w_acc) begin
         r_win[W00] <= r_win[W01];
         r_win[W01] <= r_win[W02];
         r_win[W02] <= w_lb1;
         r_win[W10] <= r_win[W11];
         r_win[W11] <= r_win[W12];
         r_win[W12] <= w_lb0;
         r_win[W20] <= r_win[W21];
         r_win[W21] <= r_win[W22];
         r_win[W22] <= pix_in;
      end
   end

   assign w00        = r_win[W00];
   assign w01        = r_win[W01];
   assign w02        = r_win[W02];
   assign w10        = r_win[W10];
   assign w11        = r_win[W11];
   assign w12        = r_win[W12];
   assign w20        = r_win[W20];
   assign w21        = r_win[W21];
   assign w22        = r_win[W22];
   assign win_valid  = r_vld;
   assign frame_done = r_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 4x4 instance against an image-array model, plus a 28x28 instance.
// Model places each accepted pixel in a 2-D image and reads windows straight out of it.
// Directed scenarios pin literal windows; a random phase exercises stalls, gaps and resyncs.
module tb_conv_window_gen;

   localparam int WD = 9;
   localparam int SW = 4;
   localparam int SH = 4;
   localparam int BW = 28;
   localparam int BH = 28;

   typedef int win_t [9];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // small instance
   logic          rst_n     = 1'b1;
   logic [WD-1:0] pix_in    = '0;
   logic          pix_valid = 1'b0;
   logic          pix_sof   = 1'b0;
   logic          win_ready = 1'b1;
   logic          pix_ready;
   logic          win_valid;
   logic          frame_done;
   logic [WD-1:0] s_w [9];

   // large instance
   logic          b_rst_n = 1'b0;
   logic [WD-1:0] b_pix   = 9'd511;
   logic          b_valid = 1'b0;
   logic          b_sof   = 1'b0;
   logic          b_wrdy  = 1'b1;
   logic          b_prdy;
   logic          b_wvld;
   logic          b_done;
   logic [WD-1:0] b_w [9];

   conv_window_gen #(.WIDTH(WD), .IMG_W(SW), .IMG_H(SH)) dut (
      .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
      .pix_ready(pix_ready),
      .w00(s_w[0]), .w01(s_w[1]), .w02(s_w[2]), .w10(s_w[3]), .w11(s_w[4]), .w12(s_w[5]),
      .w20(s_w[6]), .w21(s_w[7]), .w22(s_w[8]),
      .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
   );

   conv_window_gen dut_big (
      .clk(clk), .rst_n(b_rst_n), .pix_in(b_pix), .pix_valid(b_valid), .pix_sof(b_sof),
      .pix_ready(b_prdy),
      .w00(b_w[0]), .w01(b_w[1]), .w02(b_w[2]), .w10(b_w[3]), .w11(b_w[4]), .w12(b_w[5]),
      .w20(b_w[6]), .w21(b_w[7]), .w22(b_w[8]),
      .win_valid(b_wvld), .win_ready(b_wrdy), .frame_done(b_done)
   );

   int   tests = 0;
   int   fails = 0;
   bit   big_finished = 0;

   // model state
   int   img [SH][SW];
   int   m_r = 0, m_c = 0;
   bit   m_vld = 0, m_done = 0;
   win_t m_win;

   win_t dlog [$];
   int   done_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_step(input bit v, input int d, input bit sof, input bit rdy, output bit acc);
      int r, c;
      acc = v && (!m_vld || rdy);
      if (acc) begin
         r = sof ? 0 : m_r;
         c = sof ? 0 : m_c;
         img[r][c] = d;
         if (r >= 2 && c >= 2) begin
            m_vld = 1;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  m_win[i*3+j] = img[r-2+i][c-2+j];
            m_done = (r == SH-1) && (c == SW-1);
         end else begin
            m_vld  = 0;
            m_done = 0;
         end
         c++;
         if (c == SW) begin
            c = 0;
            r = (r == SH-1) ? 0 : r + 1;
         end
         m_r = r;
         m_c = c;
      end else begin
         if (rdy) m_vld = 0;
         m_done = 0;
      end
   endtask

   // One clock: check outputs against the model, drive inputs, advance the model.
   task automatic step(input bit v, input int d, input bit sof, input bit rdy, output bit acc);
      win_t cur;
      @(negedge clk);
      chk("win_valid", 32'(win_valid), 32'(m_vld));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      if (m_vld)
         for (int i = 0; i < 9; i++)
            chk($sformatf("w%0d%0d", i/3, i%3), 32'(s_w[i]), m_win[i]);
      if (frame_done === 1'b1) done_cnt++;
      pix_valid = v;
      pix_in    = WD'(d);
      pix_sof   = sof;
      win_ready = rdy;
      #1;
      chk("pix_ready", 32'(pix_ready), 32'(!m_vld || rdy));
      if (win_valid === 1'b1 && rdy) begin
         for (int i = 0; i < 9; i++) cur[i] = int'(s_w[i]);
         dlog.push_back(cur);
      end
      model_step(v, d, sof, rdy, acc);
   endtask

   task automatic send_pixel(input int d, input bit sof);
      bit acc;
      int guard;
      guard = 0;
      acc   = 0;
      while (!acc && guard < 20) begin
         step(1, d, sof, 1, acc);
         guard++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic send_frame(input int base, input bit sof_first);
      for (int p = 0; p < SW*SH; p++) send_pixel(base + p, sof_first && p == 0);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int k = 0; k < n; k++) step(0, 0, 0, 1, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      pix_valid = 0;
      pix_sof   = 0;
      win_ready = 1;
      #2 rst_n = 0;
      #1;
      chk("rst_win_valid", 32'(win_valid), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_pix_ready", 32'(pix_ready), 1);
      for (int i = 0; i < 9; i++) chk($sformatf("rst_w%0d%0d", i/3, i%3), 32'(s_w[i]), 0);
      repeat (2) @(negedge clk);
      rst_n  = 1;
      m_vld  = 0;
      m_done = 0;
      m_r    = 0;
      m_c    = 0;
   endtask

   task automatic chk_win(input string nm, input int idx, input win_t e);
      chk({nm, "_present"}, 32'(int'(dlog.size() > idx)), 1);
      if (dlog.size() > idx)
         for (int i = 0; i < 9; i++)
            chk($sformatf("%s_w%0d%0d", nm, i/3, i%3), dlog[idx][i], e[i]);
   endtask

   initial begin
      win_t L1 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      win_t L2 = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
      win_t L4 = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
      win_t L5 = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
      win_t LS = '{206, 207, 208, 210, 211, 212, 214, 215, 216};
      bit acc;
      int n0;

      // scenario 1: plain frame, always ready
      do_reset();
      dlog.delete();
      done_cnt = 0;
      send_frame(0, 1);
      idle(2);
      chk("s1_windows", dlog.size(), 4);
      chk("s1_frame_done", done_cnt, 1);
      chk_win("s1_win1", 0, L1);
      chk_win("s1_win4", 3, L4);
      for (int i = 0; i < 9; i++) chk($sformatf("model_win4_%0d", i), m_win[i], L4[i]);

      // scenario 2: stall on window 2 for three cycles
      dlog.delete();
      done_cnt = 0;
      for (int p = 0; p < 12; p++) send_pixel(p, p == 0);
      for (int k = 0; k < 3; k++) begin
         step(1, 12, 0, 0, acc);
         chk("s2_stall_no_accept", 32'(acc), 0);
         for (int i = 0; i < 9; i++) chk($sformatf("s2_hold_w%0d", i), 32'(s_w[i]), L2[i]);
      end
      for (int p = 12; p < 16; p++) send_pixel(p, 0);
      idle(2);
      chk("s2_windows", dlog.size(), 4);
      chk("s2_frame_done", done_cnt, 1);
      chk_win("s2_win2", 1, L2);

      // scenario 3: back-to-back frames
      dlog.delete();
      done_cnt = 0;
      send_frame(0, 1);
      send_frame(100, 1);
      idle(2);
      chk("s3_windows", dlog.size(), 8);
      chk("s3_frame_done", done_cnt, 2);
      chk_win("s3_win5", 4, L5);

      // scenario 4: reset mid-frame, then a clean frame without sof
      for (int p = 0; p < 8; p++) send_pixel(p, p == 0);
      do_reset();
      dlog.delete();
      done_cnt = 0;
      send_frame(0, 0);
      idle(2);
      chk("s4_windows", dlog.size(), 4);
      chk("s4_frame_done", done_cnt, 1);
      chk_win("s4_win1", 0, L1);
      chk_win("s4_win4", 3, L4);

      // scenario 5: sof on the seventh pixel resyncs the counters
      for (int p = 0; p < 6; p++) send_pixel(200 + p, 0);
      n0 = dlog.size();
      for (int p = 0; p < 10; p++) send_pixel(206 + p, p == 0);
      idle(1);
      chk("s5_no_early_window", dlog.size(), n0);
      send_pixel(216, 0);
      idle(1);
      chk("s5_first_window", dlog.size(), n0 + 1);
      chk_win("s5_win", n0, LS);
      for (int p = 11; p < 16; p++) send_pixel(206 + p, 0);
      idle(2);

      // random phase: gaps, stalls, occasional resync
      for (int k = 0; k < 1500; k++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 511), $urandom_range(0, 63) == 0,
              $urandom_range(0, 3) != 0, acc);
      idle(2);

      for (int k = 0; k < 2000 && !big_finished; k++) @(negedge clk);
      chk("big_finished", 32'(big_finished), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // 28x28 frame of 511s at full throughput
   initial begin
      int wins, dones, done_at, run, runs_bad, vals_bad;
      wins = 0; dones = 0; done_at = -1; run = 0; runs_bad = 0; vals_bad = 0;
      repeat (3) @(negedge clk);
      b_rst_n = 1;
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         if (b_wvld === 1'b1) begin
            wins++;
            run++;
            for (int i = 0; i < 9; i++) if (b_w[i] !== 9'd511) vals_bad++;
         end else if (run > 0) begin
            if (run != BW - 2) runs_bad++;
            run = 0;
         end
         if (b_done === 1'b1) begin
            dones++;
            done_at = wins;
         end
         b_valid = (cyc < BW*BH);
         b_sof   = (cyc == 0);
      end
      chk("big_windows", wins, (BW-2)*(BH-2));
      chk("big_frame_done", dones, 1);
      chk("big_done_on_last", done_at, (BW-2)*(BH-2));
      chk("big_row_runs_bad", runs_bad, 0);
      chk("big_values_bad", vals_bad, 0);
      big_finished = 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming 3x3 sliding-window generator that feeds the 3x3 convolution unit its a00..a22 operands.
- Accepts a raster-order pixel stream, one pixel per handshake.
- Keeps the two previous image rows in line buffers.
- Emits a full registered 3x3 window with valid/ready for every stride-1, unpadded output position.

Parameters:
- WIDTH, 9, pixel bit width, equal to the conv unit operand width.
- IMG_W, 28, image width in pixels; must be at least 3.
- IMG_H, 28, image height in pixels; must be at least 3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pix_in  in  WIDTH  input pixel, raster order.
- pix_valid  in  1  pix_in is valid.
- pix_sof  in  1  marks the first pixel of a frame; sampled only on accept.
- pix_ready  out  1  block can accept a pixel this cycle.
- w00,w01,w02,w10,w11,w12,w20,w21,w22  out  WIDTH each  window; row 0 is the oldest row, column 0 the oldest column, w22 the newest pixel.
- win_valid  out  1  window outputs are valid.
- win_ready  in  1  downstream consumes the window.
- frame_done  out  1  one-cycle pulse, coincident with the first cycle of the frame's last window.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all w* = 0, win_valid = 0, frame_done = 0, col_cnt = 0, row_cnt = 0. Line-buffer contents are don't-care.
- Accept: a pixel is accepted when pix_valid && pix_ready.
- Ready rule: pix_ready = !win_valid || win_ready, combinational. No skid buffer.
- On accept, in one cycle:
  - Window shifts left one column: w*0<=w*1, w*1<=w*2.
  - New column loads: w02<=lb1[col], w12<=lb0[col], w22<=pix_in.
  - Line buffers update: lb1[col]<=lb0[col], lb0[col]<=pix_in.
  - col_cnt increments. At IMG_W-1 it wraps to 0 and row_cnt increments. At row IMG_H-1 / col IMG_W-1 both wrap to 0.
- Sync on accept with pix_sof=1: the pixel is treated as (row 0, col 0) regardless of the counters. The counters then continue from (0,1).
- Output valid:
  - win_valid <= 1 on the cycle after accepting a pixel with row_cnt>=2 && col_cnt>=2 (latency 1).
  - win_valid <= 0 after a handshake with no new qualifying accept.
- Hold: while win_valid && !win_ready, all w* and win_valid stay stable and no pixel is accepted.
- Simultaneous win_ready and pix_valid: the window is consumed and the next pixel accepted in the same cycle. Full throughput is 1 window per clock.
- Windows per frame: (IMG_H-2)*(IMG_W-2); 676 for the defaults.
- frame_done: asserted with win_valid for exactly one cycle, after accepting pixel (IMG_H-1, IMG_W-1). It is not repeated while the window is stalled.
- Stale data:
  - Windows straddling a row wrap (col 0,1) are never marked valid.
  - Windows in rows 0,1 are never marked valid.
  - Line buffers are therefore never cleared between frames.
- Mid-operation reset: any in-flight window is dropped. The next frame starts clean at (0,0).
- Arithmetic: pure data movement, no width change. Pixel values pass through bit-exact.
- Sequencing: row_cnt/col_cnt act as the sequencer: FILL while row<2, STREAM otherwise. No separate FSM register is required.

Decomposition:
- Shared package conv_pkg:
  - Default WIDTH, IMG_W, IMG_H.
  - Counter width function clog2(IMG_W) / clog2(IMG_H).
  - Window index constants, row-major 0..8, matching the conv unit port order.
- Sub-module line_buffer (depth IMG_W, width WIDTH, one write and one read per accept, same address). Instantiated twice (lb0, lb1).
- The window register and counters stay in the top module.

Test Plan:
- IMG_W=IMG_H=4, pixels 0..15, win_ready=1 -> 4 windows, each one cycle after pixels 10,11,14,15 are accepted.
  - Window 1: w00..w22 = 0,1,2,4,5,6,8,9,10.
  - Window 4: 5,6,7,9,10,11,13,14,15.
  - frame_done with window 4 only.
- Same stream, win_ready low for 3 cycles at window 2 -> w* = 1,2,3,5,6,7,9,10,11 held stable, pix_ready=0, and pixel 12 is accepted only when win_ready rises. No loss.
- Two back-to-back frames (second frame values 100..115, pix_sof on 100) -> no window before pixel 110 of frame 2.
  - First frame-2 window = 100,101,102,104,105,106,108,109,110.
  - Total 8 windows, 2 frame_done pulses.
- rst_n low after pixel 7 of frame 1, then a new frame 0..15 -> outputs 0 during reset; afterwards the exact 4 windows of scenario 1.
- pix_sof asserted on pixel 6 of a frame -> counters resync. The first window follows the 11th pixel after the sof pixel (sof pixel counts as first).
- Default 28x28 frame, all pixels 511, continuous valid/ready -> 676 windows, all nine outputs 511, windows on consecutive cycles within each row, frame_done once.
